// File: rtl/rsa_two_power_mod_arbiter_pkg.sv
// Shared types for the RSATwoPowerMod engine arbiter.
//   MOD_WIDTH / KeyType : modulus and result width
//   IntType             : exponent type
//   ArbState_t          : arbiter FSM states
//   zero_power_result() : value of 2^0 mod m, used by the optional zero-power bypass
package rsa_two_power_mod_arbiter_pkg;

  localparam int unsigned MOD_WIDTH = 32;
  localparam int unsigned INT_WIDTH = 32;

  typedef logic [MOD_WIDTH-1:0] KeyType;
  typedef logic [INT_WIDTH-1:0] IntType;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy,
    StReturn
  } ArbState_t;

  // 2^0 mod m is 1, except that everything mod 1 is 0.
  function automatic KeyType zero_power_result(KeyType modulus);
    return (modulus == KeyType'(1)) ? KeyType'(0) : KeyType'(1);
  endfunction

endpackage

// File: rtl/rsa_two_power_mod_arbiter_if.sv
// Requester-side bundle of the RSATwoPowerMod arbiter.
//   i_valid/i_ready     : per-requester request handshake
//   i_modulus/i_power   : per-requester operands
//   o_valid/o_ready     : per-requester result handshake
//   o_out               : shared result bus, valid only for the requester whose o_valid is high
// Modports: master = requester side, slave = arbiter side.
interface rsa_two_power_mod_arbiter_if
  import rsa_two_power_mod_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);

  logic   [NUM_REQ-1:0] i_valid;
  logic   [NUM_REQ-1:0] i_ready;
  KeyType [NUM_REQ-1:0] i_modulus;
  IntType [NUM_REQ-1:0] i_power;
  logic   [NUM_REQ-1:0] o_valid;
  logic   [NUM_REQ-1:0] o_ready;
  KeyType               o_out;

  modport master (
    output i_valid, i_modulus, i_power, o_ready,
    input  i_ready, o_valid, o_out
  );

  modport slave (
    input  i_valid, i_modulus, i_power, o_ready,
    output i_ready, o_valid, o_out
  );

endinterface

// File: rtl/rsa_two_power_mod_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   i_req       : request vector
//   i_rr_ptr    : highest-priority index (registered by the parent)
//   o_grant     : one-hot grant
//   o_grant_idx : index of the granted request
//   o_any_grant : at least one request is set
module rsa_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned OWNER_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [OWNER_W-1:0] i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [OWNER_W-1:0] o_grant_idx,
  output logic               o_any_grant
);

  int unsigned        w_idx;
  logic [OWNER_W-1:0] w_sel;

  // Walk the ring starting at i_rr_ptr; the first set bit wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    w_idx       = 0;
    w_sel       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = 32'(i_rr_ptr) + i;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      w_sel = w_idx[OWNER_W-1:0];
      if (!o_any_grant && i_req[w_sel]) begin
        o_any_grant    = 1'b1;
        o_grant[w_sel] = 1'b1;
        o_grant_idx    = w_sel;
      end
    end
  end

endmodule

// File: rtl/rsa_two_power_mod_arbiter.sv
// Shares one RSATwoPowerMod engine among NUM_REQ requesters, one job at a time,
// round-robin. Results are returned only to the requester that issued the job.
//   clk, rst          : clock, asynchronous active-high reset
//   req_if (slave)    : requester handshakes, operands and shared result bus
//   eng_i_valid/ready : engine input handshake, eng_modulus/eng_power operands
//   eng_o_valid/ready : engine output handshake, eng_out result
// Optional macro RSA_ARB_ZERO_POWER_BYPASS_EN: power==0 jobs are answered locally
// (IDLE -> RETURN) without using the engine.
module rsa_two_power_mod_arbiter
  import rsa_two_power_mod_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned OWNER_W = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  rsa_two_power_mod_arbiter_if.slave   req_if,
  output logic                         eng_i_valid,
  input  logic                         eng_i_ready,
  output KeyType                       eng_modulus,
  output IntType                       eng_power,
  input  logic                         eng_o_valid,
  output logic                         eng_o_ready,
  input  KeyType                       eng_out
);

  ArbState_t          r_state;
  ArbState_t          w_state_next;
  logic [OWNER_W-1:0] r_rr_ptr;
  logic [OWNER_W-1:0] r_owner;
  KeyType             r_modulus;
  IntType             r_power;
  KeyType             r_result;

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_grant;
  logic [OWNER_W-1:0] w_grant_idx;
  logic               w_any_grant;
  KeyType             w_sel_modulus;
  IntType             w_sel_power;

  // Requests are only visible to the picker in IDLE and out of reset, so i_ready
  // stays low in every other state.
  assign w_req = (r_state == StIdle && !rst) ? req_if.i_valid : '0;

  rsa_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req       (w_req),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any_grant)
  );

  assign w_sel_modulus = req_if.i_modulus[w_grant_idx];
  assign w_sel_power   = req_if.i_power[w_grant_idx];

  assign eng_modulus   = r_modulus;
  assign eng_power     = r_power;
  assign req_if.o_out  = (r_state == StReturn) ? r_result : '0;

  always_comb begin
    w_state_next   = r_state;
    req_if.i_ready = w_grant;
    req_if.o_valid = '0;
    eng_i_valid    = 1'b0;
    eng_o_ready    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_any_grant) begin
`ifdef RSA_ARB_ZERO_POWER_BYPASS_EN
          w_state_next = (w_sel_power == '0) ? StReturn : StIssue;
`else
          w_state_next = StIssue;
`endif
        end
      end
      StIssue: begin
        eng_i_valid = 1'b1;
        if (eng_i_ready) w_state_next = StBusy;
      end
      StBusy: begin
        eng_o_ready = 1'b1;
        if (eng_o_valid) w_state_next = StReturn;
      end
      StReturn: begin
        req_if.o_valid[r_owner] = 1'b1;
        if (req_if.o_ready[r_owner]) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_modulus <= '0;
      r_power   <= '0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_any_grant) begin
        r_owner   <= w_grant_idx;
        r_modulus <= w_sel_modulus;
        r_power   <= w_sel_power;
        r_rr_ptr  <= (w_grant_idx == OWNER_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + OWNER_W'(1);
`ifdef RSA_ARB_ZERO_POWER_BYPASS_EN
        if (w_sel_power == '0) r_result <= zero_power_result(w_sel_modulus);
`endif
      end
      if (r_state == StBusy && eng_o_valid) begin
        r_result <= eng_out;
      end
    end
  end

endmodule

// File: tb/tb_rsa_two_power_mod_arbiter.sv
// Scoreboard bench for rsa_two_power_mod_arbiter with NUM_REQ=4 and a behavioural
// engine that computes 2^power mod modulus with programmable stall and latency.
module tb_rsa_two_power_mod_arbiter;
  import rsa_two_power_mod_arbiter_pkg::*;

  localparam int NR = 4;

`ifdef RSA_ARB_ZERO_POWER_BYPASS_EN
  localparam bit ZP_VIA_ENG = 1'b0;
`else
  localparam bit ZP_VIA_ENG = 1'b1;
`endif

  typedef struct packed {
    logic [31:0] m;
    logic [31:0] p;
  } job_t;

  typedef struct {
    int          owner;
    logic [31:0] val;
  } res_t;

  logic   clk;
  logic   rst;
  logic   eng_i_valid;
  logic   eng_i_ready;
  KeyType eng_modulus;
  IntType eng_power;
  logic   eng_o_valid;
  logic   eng_o_ready;
  KeyType eng_out;

  rsa_two_power_mod_arbiter_if #(.NUM_REQ(NR)) req_if ();

  rsa_two_power_mod_arbiter #(
    .NUM_REQ (NR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_if      (req_if),
    .eng_i_valid (eng_i_valid),
    .eng_i_ready (eng_i_ready),
    .eng_modulus (eng_modulus),
    .eng_power   (eng_power),
    .eng_o_valid (eng_o_valid),
    .eng_o_ready (eng_o_ready),
    .eng_out     (eng_out)
  );

  int   n_total = 0;
  int   n_bad   = 0;
  job_t pend_q[NR][$];
  job_t eng_exp_q[$];
  res_t exp_q[$];
  int   grant_q[$];
  int   eng_stall = 0;
  int   eng_lat   = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int idx_of(logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] modpow2(logic [31:0] m, logic [31:0] p);
    logic [63:0] r;
    if (m == 0) return 32'd0;
    r = 64'(32'd1 % m);
    for (int unsigned i = 0; i < p; i++) r = (r * 2) % 64'(m);
    return r[31:0];
  endfunction

  function automatic int pend_total();
    int s = 0;
    for (int r = 0; r < NR; r++) s += pend_q[r].size();
    return s;
  endfunction

  task automatic post(input int r, input logic [31:0] m, input logic [31:0] p,
                      input logic [31:0] v, input bit has_res, input bit via_eng);
    job_t j;
    res_t e;
    j.m = m;
    j.p = p;
    pend_q[r].push_back(j);
    grant_q.push_back(r);
    if (via_eng) eng_exp_q.push_back(j);
    if (has_res) begin
      e.owner = r;
      e.val   = v;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || eng_exp_q.size() != 0 || grant_q.size() != 0 ||
            pend_total() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n >= bound), 64'd0);
  endtask

  // which: 0 = eng_i_valid, 1 = eng_o_ready, 2 = o_valid[1]
  task automatic wait_cond(input int which, input int bound);
    int  n = 0;
    bit  hit = 1'b0;
    while (!hit && n < bound) begin
      @(negedge clk);
      case (which)
        0:       hit = eng_i_valid;
        1:       hit = eng_o_ready;
        default: hit = req_if.o_valid[1];
      endcase
      n++;
    end
    chk($sformatf("wait_cond%0d_timeout", which), 64'(hit), 64'd1);
  endtask

  // Requester driver: presents the head of each requester's queue and retires it
  // once the grant handshake has been seen.
  initial begin : drv
    logic [NR-1:0] acc;
    req_if.i_valid   = '0;
    req_if.i_modulus = '0;
    req_if.i_power   = '0;
    forever begin
      @(negedge clk);
      acc = req_if.i_valid & req_if.i_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (acc[r] && pend_q[r].size() > 0) void'(pend_q[r].pop_front());
        if (pend_q[r].size() > 0) begin
          req_if.i_valid[r]   = 1'b1;
          req_if.i_modulus[r] = pend_q[r][0].m;
          req_if.i_power[r]   = pend_q[r][0].p;
        end else begin
          req_if.i_valid[r] = 1'b0;
        end
      end
    end
  end

  // Behavioural engine; restarts with the shared reset.
  initial begin : engine
    int          est;
    int          cnt;
    logic [31:0] res;
    est = 0;
    cnt = 0;
    res = '0;
    eng_i_ready = 1'b0;
    eng_o_valid = 1'b0;
    eng_out     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        est = 0;
        cnt = 0;
        eng_i_ready = 1'b0;
        eng_o_valid = 1'b0;
        eng_out     = '0;
      end else begin
        case (est)
          0: if (eng_i_valid) begin
            chk("eng_req_expected", 64'(eng_exp_q.size() != 0), 64'd1);
            if (eng_exp_q.size() != 0) begin
              chk("eng_modulus", 64'(eng_modulus), 64'(eng_exp_q[0].m));
              chk("eng_power", 64'(eng_power), 64'(eng_exp_q[0].p));
            end
            if (cnt >= eng_stall) begin
              if (eng_exp_q.size() != 0) void'(eng_exp_q.pop_front());
              res = modpow2(eng_modulus, eng_power);
              eng_i_ready = 1'b1;
              cnt = 0;
              est = 1;
            end else begin
              cnt++;
            end
          end
          1: begin
            eng_i_ready = 1'b0;
            est = 2;
          end
          2: if (cnt >= eng_lat) begin
            eng_o_valid = 1'b1;
            eng_out     = res;
            cnt = 0;
            est = eng_o_ready ? 4 : 3;
          end else begin
            cnt++;
          end
          3: if (eng_o_ready) est = 4;
          default: begin
            eng_o_valid = 1'b0;
            est = 0;
          end
        endcase
      end
    end
  end

  // Monitor: grants and results are checked against the scoreboard queues.
  initial begin : mon
    int own;
    forever begin
      @(negedge clk);
      if (!rst && req_if.i_ready != '0) begin
        chk("grant_onehot", 64'($onehot(req_if.i_ready)), 64'd1);
        chk("grant_without_valid", 64'(req_if.i_ready & ~req_if.i_valid), 64'd0);
        chk("grant_outside_idle", 64'({eng_i_valid, eng_o_ready, |req_if.o_valid}), 64'd0);
        chk("grant_expected", 64'(grant_q.size() != 0), 64'd1);
        if (grant_q.size() != 0) begin
          chk("grant_owner", 64'(idx_of(req_if.i_ready)), 64'(grant_q[0]));
          void'(grant_q.pop_front());
        end
      end
      if (!rst && req_if.o_valid != '0) begin
        chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          own = idx_of(req_if.o_valid);
          chk("result_onehot", 64'($onehot(req_if.o_valid)), 64'd1);
          chk("result_owner", 64'(own), 64'(exp_q[0].owner));
          chk("result_data", 64'(req_if.o_out), 64'(exp_q[0].val));
          if (req_if.o_ready[own]) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_i_ready"}, 64'(req_if.i_ready), 64'd0);
    chk({tag, "_o_valid"}, 64'(req_if.o_valid), 64'd0);
    chk({tag, "_o_out"}, 64'(req_if.o_out), 64'd0);
    chk({tag, "_eng_i_valid"}, 64'(eng_i_valid), 64'd0);
    chk({tag, "_eng_o_ready"}, 64'(eng_o_ready), 64'd0);
  endtask

  initial begin : stim
    rst = 1'b1;
    req_if.o_ready = '1;

    // Two simultaneous requests presented while still in reset; req0 wins first.
    post(0, 32'd11, 32'd4, 32'd5, 1'b1, 1'b1);
    post(1, 32'd7, 32'd10, 32'd2, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #2 rst = 1'b0;
    wait_idle(200);

    // Single request.
    post(0, 32'd13, 32'd5, 32'd6, 1'b1, 1'b1);
    wait_idle(200);

    // Requester 3 alone: pointer wraps back to 0.
    post(3, 32'd5, 32'd3, 32'd3, 1'b1, 1'b1);
    wait_idle(200);

    // All four valid, requester 0 with a second job: grants 0,1,2,3,0.
    post(0, 32'd17, 32'd8, 32'd1, 1'b1, 1'b1);
    post(1, 32'd10, 32'd7, 32'd8, 1'b1, 1'b1);
    post(2, 32'd9, 32'd5, 32'd5, 1'b1, 1'b1);
    post(3, 32'd100, 32'd10, 32'd24, 1'b1, 1'b1);
    post(0, 32'd19, 32'd6, 32'd7, 1'b1, 1'b1);
    wait_idle(400);

    // Backpressure on both sides, with another requester waiting meanwhile.
    @(posedge clk);
    #2;
    eng_stall = 5;
    req_if.o_ready[1] = 1'b0;
    post(1, 32'd15, 32'd7, 32'd8, 1'b1, 1'b1);
    wait_cond(0, 50);
    post(2, 32'd21, 32'd6, 32'd1, 1'b1, 1'b1);
    wait_cond(2, 50);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 req_if.o_ready[1] = 1'b1;
    wait_idle(200);
    eng_stall = 0;

    // Reset while the engine is busy; the in-flight result is dropped.
    eng_lat = 8;
    post(0, 32'd13, 32'd3, 32'd8, 1'b0, 1'b1);
    wait_cond(1, 50);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #2 rst = 1'b0;
    eng_lat = 1;
    // Pointer must be back at 0, so requester 0 wins over requester 1.
    post(0, 32'd7, 32'd3, 32'd1, 1'b1, 1'b1);
    post(1, 32'd11, 32'd5, 32'd10, 1'b1, 1'b1);
    wait_idle(200);

    // Zero exponent: 2^0 mod 9 = 1, 2^0 mod 1 = 0.
    post(2, 32'd9, 32'd0, 32'd1, 1'b1, ZP_VIA_ENG);
    post(3, 32'd1, 32'd0, 32'd0, 1'b1, ZP_VIA_ENG);
    wait_idle(200);

    repeat (3) @(negedge clk);
    chk("final_o_valid", 64'(req_if.o_valid), 64'd0);
    chk("final_eng_i_valid", 64'(eng_i_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rsa_two_power_mod_arbiter.md
Name: rsa_two_power_mod_arbiter

Overview:
Shares one RSATwoPowerMod engine (computes 2^power mod modulus) among NUM_REQ independent requesters, such as the Montgomery-constant setup paths of several RSA cores.
- Round-robin arbitration; one job in flight at a time.
- Drives the engine's valid/ready input and output channels.
- Returns each result only to the requester that issued it.
- Sits between the requesters and a single engine instance in the RSA top level.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
OWNER_W, $clog2(NUM_REQ), owner/pointer width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_valid  in  NUM_REQ  per-requester request valid
i_ready  out  NUM_REQ  per-requester request accept
i_modulus  in  NUM_REQ x MOD_WIDTH (KeyType array)  per-requester modulus
i_power  in  NUM_REQ x IntType  per-requester exponent
o_valid  out  NUM_REQ  per-requester result valid
o_ready  in  NUM_REQ  per-requester result accept
o_out  out  MOD_WIDTH  result bus shared by all requesters; meaningful only for the requester whose o_valid is high
eng_i_valid  out  1  to engine i_valid
eng_i_ready  in  1  from engine i_ready
eng_modulus  out  MOD_WIDTH  to engine i_modulus
eng_power  out  IntType  to engine i_power
eng_o_valid  in  1  from engine o_valid
eng_o_ready  out  1  to engine o_ready
eng_out  in  MOD_WIDTH  from engine o_out

Behaviour:
- Reset (async, rst=1): state IDLE, rr_ptr=0, owner=0, result reg=0, all latched data=0.
- Reset outputs: i_ready=0, o_valid=0, o_out=0, eng_i_valid=0, eng_o_ready=0.
- FSM states: IDLE, ISSUE, BUSY, RETURN.
- IDLE:
  - Grant = first set bit of i_valid, searching circularly from rr_ptr.
  - i_ready[grant]=1 combinationally; all other bits 0. No grant when i_valid=0.
  - On grant: latch owner, modulus and power; set rr_ptr=(owner+1) mod NUM_REQ; go to ISSUE.
- ISSUE:
  - eng_i_valid=1; eng_modulus and eng_power come from the latched registers.
  - On eng_i_ready go to BUSY.
- BUSY:
  - eng_o_ready=1.
  - On eng_o_valid, capture eng_out into the result reg and go to RETURN.
- RETURN:
  - o_valid[owner]=1; o_out=result reg.
  - On o_ready[owner] go to IDLE. No request is accepted in the same cycle.
- Latency: request accept at cycle T, eng_i_valid at T+1. Earliest o_valid is 1 cycle after the engine's o_valid handshake completes.
- Valid/ready rules:
  - i_ready may depend on i_valid; i_valid must not depend on i_ready.
  - Requesters hold i_valid and data stable until accepted.
  - o_ready of non-owners is ignored.
- Simultaneous requests: exactly one grant per IDLE cycle. With rr_ptr=k, requester k wins if valid, else the next higher index, wrapping at NUM_REQ-1 to 0.
- Fairness: a requester with i_valid held high is granted within NUM_REQ jobs.
- Wrap-around: rr_ptr for owner NUM_REQ-1 returns to 0.
- Reset mid-operation: the FSM returns to IDLE immediately and any in-flight result is discarded. The engine shares the same reset source (polarity adapted at top level), so both restart together.
- Requester i_valid changes while the block is not in IDLE: no effect.
- power==0 without the optional feature: forwarded to the engine unchanged; engine behaviour is the caller's responsibility.

Optional Feature:
Macro: RSA_ARB_ZERO_POWER_BYPASS_EN
- Defined: a granted request with power==0 goes IDLE->RETURN without touching the engine.
  - Result = 0 if modulus==1, else 1.
  - eng_i_valid stays 0 for that job; rr_ptr still advances.
- Undefined: all requests go through the engine, including power==0.

Decomposition:
- RSA_pkg additions: ArbState_t enum (IDLE/ISSUE/BUSY/RETURN). KeyType, IntType and MOD_WIDTH are reused from RSA_pkg.
- Sub-module rsa_rr_arbiter (parameter NUM_REQ):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; rr_ptr is registered in the parent.

Test Plan:
1. Single request: req0, modulus=13, power=5. Engine returns 6 -> o_valid[0] only, o_out=6. Engine sees eng_modulus=13, eng_power=5.
2. Simultaneous: i_valid=2'b11 at reset (rr_ptr=0) -> req0 served first, then req1 with no re-arbitration gap beyond IDLE. Results 2^4 mod 11=5 and 2^10 mod 7=2 are delivered to the correct owners.
3. Round-robin fairness, NUM_REQ=4: all four held valid -> grant order 0,1,2,3,0. Requester 3's pointer wraps to 0.
4. Backpressure: engine holds i_ready=0 for 5 cycles, then requester holds o_ready=0 for 4 cycles -> eng_i_valid and o_valid stay high with stable data; no new i_ready during the job.
5. Reset mid-BUSY: assert rst for 1 cycle -> all outputs 0 and state IDLE; a new request then completes normally.
6. Zero power (feature on): power=0, modulus=9 -> o_out=1, eng_i_valid never asserted. modulus=1 -> o_out=0. Feature off -> request is forwarded to the engine.
